// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, instruction field positions and sequencer state for alu_sequencer
package alu_pkg;

    localparam int DW = 8;

    localparam logic [3:0] OP_NOT   = 4'b0001;
    localparam logic [3:0] OP_LOADI = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_CLR   = 4'b1010;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RA_MSB  = 9;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } seq_state_t;

    // Opcodes that need a trip through the external ALU
    function automatic logic is_alu_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_CLR: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return is_alu_op(op) || (op == OP_LOADI);
    endfunction

endpackage

// File: rtl/regfile4x8.sv
// rtl/regfile4x8.sv - register file with two operand read ports, a debug port and one write port
module regfile4x8
    import alu_pkg::*;
#(
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];

    // Combinational read ports
    always_comb begin
        ra_data  = rf_q[ra_addr];
        rb_data  = rf_q[rb_addr];
        dbg_data = rf_q[dbg_addr];
    end

    // Next register contents: single write port
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (we) begin
            rf_d[waddr] = wdata;
        end
    end

    // Storage, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issue-side controller driving the external 8-bit ALU and writing results back
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_mode,
    input  logic [7:0]  alu_s,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic [1:0]  res_rd,
    output logic        err,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    seq_state_t state_q, state_d;

    logic [3:0]    op_q, op_d;
    logic [1:0]    rd_q, rd_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [3:0]    alu_mode_q, alu_mode_d;
    logic          res_valid_q, res_valid_d;
    logic          err_q, err_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic [1:0]    res_rd_q, res_rd_d;

    logic [3:0]    opcode_in;
    logic          accept;
    logic          rf_we;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_a, rf_b;

    assign opcode_in = instr[OPC_MSB:OPC_LSB];
    assign accept    = (state_q == ST_IDLE) && instr_valid;

    // Operand ports address the incoming instruction so operands are registered at accept
    regfile4x8 #(
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (rf_wdata),
        .ra_addr  (instr[RA_MSB:RA_LSB]),
        .rb_addr  (instr[RB_MSB:RB_LSB]),
        .dbg_addr (dbg_sel),
        .ra_data  (rf_a),
        .rb_data  (rf_b),
        .dbg_data (dbg_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: LOADI and illegal opcodes skip EXEC since they never touch the ALU
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_d = is_alu_op(opcode_in) ? ST_EXEC : ST_WB;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs: handshake and write-back enable
    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        rf_we       = (state_q == ST_WB) && is_legal_op(op_q);
        rf_wdata    = (op_q == OP_LOADI) ? imm_q : result_q;
    end

    // Datapath next values; ALU drive is registered so it is stable for all of EXEC
    always_comb begin
        op_d        = accept ? opcode_in : op_q;
        rd_d        = accept ? instr[RD_MSB:RD_LSB] : rd_q;
        imm_d       = accept ? instr[IMM_MSB:IMM_LSB] : imm_q;
        alu_a_d     = (state_d == ST_EXEC) ? rf_a : alu_a_q;
        alu_b_d     = (state_d == ST_EXEC) ? rf_b : alu_b_q;
        alu_mode_d  = (state_d == ST_EXEC) ? opcode_in : OP_CLR;
        result_d    = (state_q == ST_EXEC) ? alu_s : result_q;
        res_valid_d = rf_we;
        err_d       = (state_q == ST_WB) && !is_legal_op(op_q);
        res_data_d  = rf_we ? rf_wdata : res_data_q;
        res_rd_d    = rf_we ? rd_q : res_rd_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_CLR;
            rd_q        <= '0;
            imm_q       <= '0;
            result_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_mode_q  <= OP_CLR;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
        end else begin
            op_q        <= op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            result_q    <= result_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_mode_q  <= alu_mode_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_mode  = alu_mode_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with an ALU model
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        instr_ready;
    logic [7:0]  alu_a, alu_b, alu_s;
    logic [3:0]  alu_mode;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  res_rd;
    logic        err;
    logic [1:0]  dbg_sel = 2'd0;
    logic [7:0]  dbg_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_mode    (alu_mode),
        .alu_s       (alu_s),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .err         (err),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    always_comb begin
        case (alu_mode)
            4'b0011: alu_s = 8'(alu_a + alu_b);
            4'b0100: alu_s = 8'(alu_a + ~alu_b + 8'd1);
            4'b0101: alu_s = alu_a & alu_b;
            4'b0110: alu_s = alu_a | alu_b;
            4'b0001: alu_s = ~alu_a;
            default: alu_s = 8'h00;
        endcase
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic read_rf(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        dbg_sel = sel;
        #1;
        check_eq(tag, {8'h0, dbg_data}, {8'h0, exp});
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb, 6'b0};
    endfunction

    function automatic logic [15:0] mk_loadi(input logic [1:0] rd, input logic [7:0] imm);
        return {4'b0010, rd, 2'b00, imm};
    endfunction

    task automatic run(input string name, input logic [15:0] ins, input logic [3:0] exp_mode,
                       input int exp_lat, input bit exp_err, input logic [7:0] exp_data,
                       input logic [1:0] exp_rd);
        int n;
        @(negedge clk);
        check_eq({name, "_ready_idle"}, {15'h0, instr_ready}, 16'h1);
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'h0;
        @(negedge clk);
        n = 1;
        check_eq({name, "_mode"}, {12'h0, alu_mode}, {12'h0, exp_mode});
        check_eq({name, "_ready_busy"}, {15'h0, instr_ready}, 16'h0);
        while (!res_valid && !err && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq({name, "_lat"}, 16'(n), 16'(exp_lat));
        check_eq({name, "_err"}, {15'h0, err}, {15'h0, exp_err});
        check_eq({name, "_res_valid"}, {15'h0, res_valid}, {15'h0, !exp_err});
        check_eq({name, "_ready_back"}, {15'h0, instr_ready}, 16'h1);
        check_eq({name, "_res_data"}, {8'h0, res_data}, {8'h0, exp_data});
        check_eq({name, "_res_rd"}, {14'h0, res_rd}, {14'h0, exp_rd});
        if (!exp_err) begin
            read_rf({name, "_dbg"}, ins[11:10], exp_data);
        end
        @(negedge clk);
        check_eq({name, "_pulse_end"}, {14'h0, res_valid, err}, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] rdy_pat;
        logic [9:0] rv_pat;
        logic       any_pulse;

        #12;
        check_eq("rst_ready", {15'h0, instr_ready}, 16'h1);
        check_eq("rst_res_valid", {15'h0, res_valid}, 16'h0);
        check_eq("rst_err", {15'h0, err}, 16'h0);
        check_eq("rst_res_data", {8'h0, res_data}, 16'h0);
        check_eq("rst_res_rd", {14'h0, res_rd}, 16'h0);
        check_eq("rst_alu_ab", {alu_a, alu_b}, 16'h0);
        check_eq("rst_alu_mode", {12'h0, alu_mode}, 16'h000A);
        for (int i = 0; i < 4; i++) begin
            read_rf("rst_rf", 2'(i), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run("loadi_r1", mk_loadi(2'd1, 8'h05), 4'hA, 2, 1'b0, 8'h05, 2'd1);
        run("loadi_r2", mk_loadi(2'd2, 8'h03), 4'hA, 2, 1'b0, 8'h03, 2'd2);
        run("add_r3", mk(4'h3, 2'd3, 2'd1, 2'd2), 4'h3, 3, 1'b0, 8'h08, 2'd3);
        check_eq("add_hold_ab", {alu_a, alu_b}, 16'h0503);
        check_eq("add_mode_idle", {12'h0, alu_mode}, 16'h000A);
        run("sub_r0", mk(4'h4, 2'd0, 2'd2, 2'd1), 4'h4, 3, 1'b0, 8'hFE, 2'd0);
        run("and_r0", mk(4'h5, 2'd0, 2'd1, 2'd2), 4'h5, 3, 1'b0, 8'h01, 2'd0);
        run("or_r0", mk(4'h6, 2'd0, 2'd1, 2'd2), 4'h6, 3, 1'b0, 8'h07, 2'd0);
        run("not_r0", mk(4'h1, 2'd0, 2'd1, 2'd0), 4'h1, 3, 1'b0, 8'hFA, 2'd0);
        run("clr_r0", mk(4'hA, 2'd0, 2'd1, 2'd2), 4'hA, 3, 1'b0, 8'h00, 2'd0);
        run("loadi_r1ff", mk_loadi(2'd1, 8'hFF), 4'hA, 2, 1'b0, 8'hFF, 2'd1);
        run("add_wrap", mk(4'h3, 2'd1, 2'd1, 2'd1), 4'h3, 3, 1'b0, 8'hFE, 2'd1);

        run("illegal", mk(4'hF, 2'd2, 2'd1, 2'd1), 4'hA, 2, 1'b1, 8'hFE, 2'd1);
        read_rf("illegal_rf0", 2'd0, 8'h00);
        read_rf("illegal_rf1", 2'd1, 8'hFE);
        read_rf("illegal_rf2", 2'd2, 8'h03);
        read_rf("illegal_rf3", 2'd3, 8'h08);

        // Valid held high across three ADD r3=r1+r2 (0xFE+0x03)
        rdy_pat = '0;
        rv_pat = '0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = mk(4'h3, 2'd3, 2'd1, 2'd2);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            rdy_pat[i] = instr_ready;
            rv_pat[i] = res_valid;
            if (i == 6) begin
                @(posedge clk);
                #1;
                instr_valid = 1'b0;
            end
        end
        check_eq("b2b_ready_pattern", {6'h0, rdy_pat}, 16'h0249);
        check_eq("b2b_res_valid_pattern", {6'h0, rv_pat}, 16'h0248);
        check_eq("b2b_res_data", {8'h0, res_data}, 16'h0001);
        read_rf("b2b_rf3", 2'd3, 8'h01);

        // Reset asserted during EXEC of ADD r3
        @(negedge clk);
        instr_valid = 1'b1;
        instr = mk(4'h3, 2'd3, 2'd1, 2'd2);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check_eq("rstx_exec_mode", {12'h0, alu_mode}, 16'h0003);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rstx_ready", {15'h0, instr_ready}, 16'h1);
        check_eq("rstx_pulses", {14'h0, res_valid, err}, 16'h0);
        check_eq("rstx_res", {6'h0, res_rd, res_data}, 16'h0);
        check_eq("rstx_alu_ab", {alu_a, alu_b}, 16'h0);
        check_eq("rstx_alu_mode", {12'h0, alu_mode}, 16'h000A);
        read_rf("rstx_rf3", 2'd3, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        any_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_pulse = any_pulse | res_valid | err;
        end
        check_eq("rstx_no_pulse", {15'h0, any_pulse}, 16'h0);
        check_eq("rstx_idle_ready", {15'h0, instr_ready}, 16'h1);
        read_rf("rstx_rf1", 2'd1, 8'h00);
        read_rf("rstx_rf3_after", 2'd3, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
